// File: rtl/display_pkg.sv
// Shared definitions for the display arbiter: state encoding, requester count,
// fault channel index and digit widths.
package display_pkg;

    localparam int NREQ      = 3;
    localparam int FAULT_IDX = 0;
    localparam int NIBBLE_W  = 4;
    localparam int NDIGITS   = 4;
    localparam int DATA_W    = NIBBLE_W * NDIGITS;
    localparam int IDX_W     = $clog2(NREQ);
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester selection starting after the last owner; the fault
// channel always wins when it is requesting.
module rr_pick
    import display_pkg::*;
(
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [NREQ-1:0]  o_pick
);

    always_comb begin
        logic             w_found;
        logic [IDX_W-1:0] w_idx;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        o_pick  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        if (i_req[FAULT_IDX]) begin
            o_pick[FAULT_IDX] = 1'b1;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                w_idx = IDX_W'((int'(i_last) + k) % NREQ);
                if (!w_found && i_req[w_idx]) begin
                    o_pick[w_idx] = 1'b1;
                    w_found       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates ownership of the 4-digit display between three requesters with a
// minimum dwell time, a one-cycle blanking gap on handover and fault preemption.
module display_arbiter
    import display_pkg::*;
#(
    parameter int HOLD_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [DATA_W-1:0]   req_data0,
    input  logic [DATA_W-1:0]   req_data1,
    input  logic [DATA_W-1:0]   req_data2,
    output logic [NREQ-1:0]     grant,
    output logic [NIBBLE_W-1:0] data1,
    output logic [NIBBLE_W-1:0] data2,
    output logic [NIBBLE_W-1:0] data3,
    output logic [NIBBLE_W-1:0] data4,
    output logic                blank
);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NREQ - 1);

    state_e            r_state, w_next_state;
    logic [NREQ-1:0]   r_grant, w_next_grant, w_pick;
    logic [IDX_W-1:0]  r_last, w_next_last;
    logic [CNT_W-1:0]  r_cnt, w_next_cnt;
    logic [DATA_W-1:0] r_data, w_next_data, w_owner_data;
    logic              r_blank;
    logic              w_others, w_owner_req, w_preempt;
    logic [DATA_W-1:0] w_req_data [NREQ];

    assign w_req_data[0] = req_data0;
    assign w_req_data[1] = req_data1;
    assign w_req_data[2] = req_data2;

    assign w_others    = |(req & ~r_grant);
    assign w_owner_req = |(req & r_grant);
    assign w_preempt   = req[FAULT_IDX] & ~r_grant[FAULT_IDX];

    rr_pick u_rr_pick (
        .i_req  (req),
        .i_last (r_last),
        .o_pick (w_pick)
    );

    always_comb begin
        w_owner_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_owner_data = w_owner_data | (w_req_data[i] & {DATA_W{r_grant[i]}});
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_last  = r_last;
        w_next_cnt   = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
        case (r_state)
            ST_IDLE, ST_SWITCH: begin
                if (|req) begin
                    w_next_state = ST_HOLD;
                    w_next_grant = w_pick;
                    w_next_last  = onehot_to_idx(w_pick);
                    w_next_cnt   = DWELL_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                    w_next_grant = '0;
                end
            end
            ST_HOLD: begin
                // A fault owner keeps the display past expiry until it drops its request.
                if (!w_owner_req || w_preempt ||
                    (r_cnt == '0 && w_others && !r_grant[FAULT_IDX])) begin
                    w_next_state = w_others ? ST_SWITCH : ST_IDLE;
                    w_next_grant = '0;
                end else if (r_cnt == '0) begin
                    w_next_cnt = DWELL_LOAD;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_grant = '0;
            end
        endcase
    end

    always_comb begin
        w_next_data = r_data;
        if (w_next_state == ST_IDLE) begin
            w_next_data = '0;
        end else if (r_state == ST_HOLD) begin
            w_next_data = w_owner_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= LAST_RST;
            r_cnt   <= '0;
            r_data  <= '0;
            r_blank <= 1'b1;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            r_last  <= w_next_last;
            r_cnt   <= w_next_cnt;
            r_data  <= w_next_data;
            r_blank <= (w_next_state != ST_HOLD);
        end
    end

    assign grant = r_grant;
    assign blank = r_blank;
    assign data1 = r_data[0*NIBBLE_W +: NIBBLE_W];
    assign data2 = r_data[1*NIBBLE_W +: NIBBLE_W];
    assign data3 = r_data[2*NIBBLE_W +: NIBBLE_W];
    assign data4 = r_data[3*NIBBLE_W +: NIBBLE_W];

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000, minimum clk cycles a non-fault owner keeps the display (legal range 2..65535).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 req  input  3  per-requester display request; bit 0 is the fault channel.
REQ-005 req_data0, req_data1, req_data2  input  16 each  four nibbles per requester; [3:0] -> digit 1 ... [15:12] -> digit 4.
REQ-006 grant  output  3  one-hot current owner; all zero when idle.
REQ-007 data1, data2, data3, data4  output  4 each  digit nibbles for the 4x8 display path.
REQ-008 blank  output  1  high when no requester owns the display.

Function
REQ-009 The block SHALL implement states IDLE, HOLD and SWITCH, all registered.
REQ-010 IDLE: grant=0, blank=1, data1..data4=0; any req bit high SHALL move to HOLD on the next edge with grant set to the selected requester.
REQ-011 Selection SHALL be round-robin starting at the index after the last owner (after reset, index 0 is checked first), except per REQ-015.
REQ-012 On entry to HOLD the dwell counter SHALL load HOLD_CYCLES-1 and decrement once per cycle, saturating at 0.
REQ-013 While in HOLD, data1..data4 SHALL be registered from the owner's req_data each cycle (one-cycle latency); blank=0.
REQ-014 When the dwell counter is 0 in HOLD: if another requester is high -> SWITCH; else if owner still high -> reload counter and stay; else -> IDLE.
REQ-015 Fault preemption: req[0] rising while another owner holds SHALL move to SWITCH on the next edge regardless of the counter; while req[0] owns, no other requester SHALL be granted until req[0] drops.
REQ-016 Owner dropping its req in HOLD before counter expiry SHALL end the hold at the next edge (SWITCH if others pending, else IDLE).
REQ-017 SWITCH lasts exactly one cycle: grant=0, blank=1, data held at last value; next edge SHALL grant the next owner and enter HOLD (or IDLE if all req low).
REQ-018 grant SHALL be one-hot or zero at all times; grant and blank SHALL never both be asserted.
REQ-019 Requester data changes SHALL not alter ownership; only req bits and the counter drive transitions.
REQ-020 Simultaneous owner drop and counter expiry SHALL follow REQ-016.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, grant=0, blank=1, data1..data4=0, counter=0, round-robin pointer=2 (so index 0 is checked first).
REQ-022 Reset asserted mid-HOLD SHALL discard ownership; after release, arbitration restarts per REQ-011.

Structure
REQ-023 A shared package display_pkg SHALL hold the state encoding, NREQ=3, the fault index 0 and the digit-nibble width 4.
REQ-024 Round-robin selection SHALL live in one sub-module rr_pick (inputs req, last owner; output one-hot pick); the counter and FSM stay in display_arbiter.
REQ-025 Outputs data1..data4 SHALL connect directly to the existing display top's digit inputs without extra logic.

Verification (HOLD_CYCLES=4 unless stated)
REQ-026 Reset then req=3'b010, req_data1=16'h4321 -> grant=3'b010 one cycle later, data1..4=1,2,3,4 the next cycle, blank=0.
REQ-027 req=3'b110 held -> owner 1 for 4 cycles, one SWITCH cycle (blank=1, grant=0), owner 2 for 4 cycles, then alternate.
REQ-028 Owner 2 holding, req[0] rises at dwell count 2 -> SWITCH next edge, grant=3'b001 edge after; req[1], req[2] stay ungranted until req[0] falls.
REQ-029 Single requester 1 held 12 cycles -> grant stays 3'b010 continuously, no SWITCH cycle; drop req -> IDLE next edge, blank=1.
REQ-030 rst_n pulsed low mid-HOLD -> grant=0, blank=1, data=0 within the same cycle, without a clock edge; after release req=3'b111 -> grant=3'b001 first.
